// File: rtl/punc_fetch_unit.sv
// PUnC LC3 instruction fetch stage: owns PC/IR, issues one read per fetch request,
// and presents the IR plus pre-decoded fields to control over a valid/ack handshake.
module punc_fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              pc_ld,
    input  logic [ADDR_W-1:0] pc_ld_val,
    input  logic              ir_ack,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        opcode,
    output logic [2:0]        dr,
    output logic [2:0]        sr1,
    output logic [2:0]        sr2,
    output logic [15:0]       imm5_sext,
    output logic [15:0]       off6_sext,
    output logic [15:0]       off9_sext,
    output logic [15:0]       off11_sext,
    output logic              halted,
    output logic              fetch_timeout,
    output logic              protocol_err
);

    localparam int unsigned CNT_W = 10;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              rd_en_q, rd_en_d;
    logic              halted_q, halted_d;
    logic              timeout_q, timeout_d;
    logic              perr_q, perr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_halt;

    assign is_halt = (ir_q[15:12] == 4'hF) && (ir_q[7:0] == 8'h25);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        rd_en_d    = 1'b0;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        perr_d     = perr_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pc_ld) pc_d = pc_ld_val;
                if (fetch_req) begin
                    state_d = StIssue;
                    rd_en_d = 1'b1;
                end
            end
            StIssue: begin
                if (pc_ld) perr_d = 1'b1;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (pc_ld) perr_d = 1'b1;
                if (mem_rd_valid) begin
                    ir_d       = mem_rd_data;
                    pc_d       = pc_q + ADDR_W'(1);
                    ir_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StHold;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the read; PC and IR keep their pre-fetch values.
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (pc_ld) pc_d = pc_ld_val;
                if (ir_ack) begin
                    ir_valid_d = 1'b0;
                    if (is_halt) begin
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            perr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            rd_en_q    <= rd_en_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            perr_q     <= perr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_rd_en     = rd_en_q;
    assign mem_rd_addr   = pc_q;
    assign ir_valid      = ir_valid_q;
    assign ir            = ir_q;
    assign pc            = pc_q;
    assign halted        = halted_q;
    assign fetch_timeout = timeout_q;
    assign protocol_err  = perr_q;

    // Decode fields follow IR directly; only meaningful while ir_valid is high.
    assign opcode     = ir_q[15:12];
    assign dr         = ir_q[11:9];
    assign sr1        = ir_q[8:6];
    assign sr2        = ir_q[2:0];
    assign imm5_sext  = {{11{ir_q[4]}}, ir_q[4:0]};
    assign off6_sext  = {{10{ir_q[5]}}, ir_q[5:0]};
    assign off9_sext  = {{7{ir_q[8]}}, ir_q[8:0]};
    assign off11_sext = {{5{ir_q[10]}}, ir_q[10:0]};

endmodule

// File: tb/tb_punc_fetch_unit.sv
// Directed bench for punc_fetch_unit: 1-cycle memory responder plus a scoreboard of
// expected IR/PC captures popped whenever ir_valid is observed.
module tb_punc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, fetch_req, pc_ld, ir_ack, mem_rd_valid;
    logic [15:0] pc_ld_val, mem_rd_data;
    logic        mem_rd_en, ir_valid, halted, fetch_timeout, protocol_err;
    logic [15:0] mem_rd_addr, ir, pc, imm5_sext, off6_sext, off9_sext, off11_sext;
    logic [3:0]  opcode;
    logic [2:0]  dr, sr1, sr2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [0:65535];
    logic        mem_auto = 1'b1;
    logic        force_valid = 1'b0;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = '0;

    always #5 clk = ~clk;

    punc_fetch_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_ld(pc_ld), .pc_ld_val(pc_ld_val),
        .ir_ack(ir_ack), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .ir_valid(ir_valid),
        .ir(ir), .pc(pc), .opcode(opcode), .dr(dr), .sr1(sr1), .sr2(sr2),
        .imm5_sext(imm5_sext), .off6_sext(off6_sext), .off9_sext(off9_sext),
        .off11_sext(off11_sext), .halted(halted), .fetch_timeout(fetch_timeout),
        .protocol_err(protocol_err)
    );

    // Memory answers one cycle after seeing the read strobe.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rd_valid = (pend && mem_auto) || force_valid;
            mem_rd_data  = mem[pend_addr];
            pend         = mem_rd_en;
            pend_addr    = mem_rd_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Request a fetch (optionally with a same-cycle PC load) and check the read strobe.
    task automatic do_fetch(input logic [15:0] addr, input bit ld, input bit push);
        exp_t e;
        fetch_req = 1'b1;
        pc_ld     = ld;
        pc_ld_val = addr;
        if (push) begin
            e.ir = mem[addr];
            e.pc = addr + 16'd1;
            sb.push_back(e);
        end
        step();
        fetch_req = 1'b0;
        pc_ld     = 1'b0;
        chk("rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("rd_addr", {16'd0, mem_rd_addr}, {16'd0, addr});
    endtask

    // Wait (bounded) for ir_valid, then compare against the scoreboard head.
    task automatic wait_valid(output int steps);
        exp_t e;
        steps = 0;
        while (!ir_valid && steps < 20) begin
            step();
            steps++;
        end
        chk("ir_valid_seen", {31'd0, ir_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("ir", {16'd0, ir}, {16'd0, e.ir});
            chk("pc", {16'd0, pc}, {16'd0, e.pc});
        end
    endtask

    task automatic ack(input bit ld, input logic [15:0] val);
        ir_ack    = 1'b1;
        pc_ld     = ld;
        pc_ld_val = val;
        step();
        ir_ack = 1'b0;
        pc_ld  = 1'b0;
        chk("ir_valid_drop", {31'd0, ir_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int rd_seen;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1261;
        mem[16'h0001] = 16'h0FFF;
        mem[16'h0002] = 16'h107F;
        mem[16'hFFFF] = 16'h5020;
        mem[16'h3000] = 16'h6042;
        mem[16'h3001] = 16'h1DA5;
        mem[16'h3002] = 16'h2A07;
        mem[16'h3003] = 16'hF025;

        rst = 1'b1; fetch_req = 1'b0; pc_ld = 1'b0; pc_ld_val = '0; ir_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_pc", {16'd0, pc}, 32'h0);
        chk("rst_ir", {16'd0, ir}, 32'h0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_flags", {29'd0, halted, fetch_timeout, protocol_err}, 32'd0);

        // Basic fetch of ADD R1,R1,#1 with 3-cycle latency.
        do_fetch(16'h0000, 1'b0, 1'b1);
        wait_valid(n);
        chk("latency", n, 32'd2);
        chk("opcode", {28'd0, opcode}, 32'h1);
        chk("dr", {29'd0, dr}, 32'h1);
        chk("sr1", {29'd0, sr1}, 32'h1);
        chk("imm5", {16'd0, imm5_sext}, 32'h0001);
        ack(1'b0, 16'h0);
        step();
        chk("idle_rd_en", {31'd0, mem_rd_en}, 32'd0);

        // Sign extension of negative offsets/immediates.
        do_fetch(16'h0001, 1'b0, 1'b1);
        wait_valid(n);
        chk("off9", {16'd0, off9_sext}, 32'hFFFF);
        chk("off11", {16'd0, off11_sext}, 32'hFFFF);
        chk("off6", {16'd0, off6_sext}, 32'hFFFF);
        ack(1'b0, 16'h0);
        do_fetch(16'h0002, 1'b0, 1'b1);
        wait_valid(n);
        chk("imm5_neg", {16'd0, imm5_sext}, 32'hFFFF);
        chk("sr2", {29'd0, sr2}, 32'h7);
        ack(1'b0, 16'h0);

        // PC load with fetch_req, wrap FFFF->0000, then branch with ack.
        do_fetch(16'hFFFF, 1'b1, 1'b1);
        wait_valid(n);
        ack(1'b1, 16'h3000);
        chk("pc_branch", {16'd0, pc}, 32'h3000);
        do_fetch(16'h3000, 1'b0, 1'b1);
        wait_valid(n);
        ack(1'b0, 16'h0);

        // Timeout with memory silent: 4 WAIT cycles, then IDLE.
        mem_auto = 1'b0;
        do_fetch(16'h3001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("timeout_early", {31'd0, fetch_timeout}, 32'd0);
        step();
        chk("timeout", {31'd0, fetch_timeout}, 32'd1);
        chk("timeout_pc", {16'd0, pc}, 32'h3001);
        chk("timeout_ir", {16'd0, ir}, 32'h6042);
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        step();
        step();
        chk("late_valid", {31'd0, ir_valid}, 32'd0);
        chk("late_ir", {16'd0, ir}, 32'h6042);
        mem_auto = 1'b1;
        do_fetch(16'h3001, 1'b0, 1'b1);
        wait_valid(n);
        ack(1'b0, 16'h0);

        // pc_ld during WAIT: flagged and discarded.
        do_fetch(16'h3002, 1'b0, 1'b1);
        chk("perr_before", {31'd0, protocol_err}, 32'd0);
        step();
        pc_ld = 1'b1;
        pc_ld_val = 16'h1234;
        step();
        pc_ld = 1'b0;
        wait_valid(n);
        chk("perr", {31'd0, protocol_err}, 32'd1);
        ack(1'b0, 16'h0);

        // HALT: terminal until reset.
        do_fetch(16'h3003, 1'b0, 1'b1);
        wait_valid(n);
        chk("halt_opcode", {28'd0, opcode}, 32'hF);
        ack(1'b0, 16'h0);
        chk("halted", {31'd0, halted}, 32'd1);
        rd_seen = 0;
        fetch_req = 1'b1;
        pc_ld = 1'b1;
        pc_ld_val = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_rd_en) rd_seen++;
        end
        fetch_req = 1'b0;
        pc_ld = 1'b0;
        chk("halt_no_rd", rd_seen, 32'd0);
        chk("halt_pc", {16'd0, pc}, 32'h3004);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_pc", {16'd0, pc}, 32'h0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);

        // Reset during WAIT, then a stale valid must be ignored.
        mem_auto = 1'b0;
        do_fetch(16'h0000, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        step();
        chk("rst_wait_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_wait_ir", {16'd0, ir}, 32'h0);
        chk("rst_wait_pc", {16'd0, pc}, 32'h0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/punc_fetch_unit.md
Name: punc_fetch_unit

Overview:
Instruction fetch stage of the PUnC LC3 processor, sitting directly upstream of the control FSM. It owns the PC and IR, issues one memory read per fetch request, captures the returned word, advances the PC, and presents the IR plus pre-decoded LC3 fields to control through a valid/ack handshake. It detects HALT (TRAP x25) and then stops fetching until reset.

Parameters:
ADDR_W, 16, PC and memory address width
DATA_W, 16, instruction word width
RESET_PC, 16'h0000, PC value after reset
TIMEOUT, 64, maximum WAIT cycles before a fetch is abandoned (range 2..1023)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
fetch_req  input  1  control requests next instruction; sampled only in IDLE
pc_ld  input  1  load PC from pc_ld_val (branch/JMP/JSR target)
pc_ld_val  input  ADDR_W  new PC value
ir_ack  input  1  control has consumed IR; sampled only in HOLD
mem_rd_en  output  1  one-cycle read strobe to instruction memory
mem_rd_addr  output  ADDR_W  read address, equal to the PC register
mem_rd_data  input  DATA_W  read data
mem_rd_valid  input  1  read data valid; honoured only in WAIT
ir_valid  output  1  IR holds a fresh instruction
ir  output  DATA_W  instruction register
pc  output  ADDR_W  PC register (already incremented past IR once ir_valid is high)
opcode  output  4  ir[15:12]
dr  output  3  ir[11:9]
sr1  output  3  ir[8:6]
sr2  output  3  ir[2:0]
imm5_sext  output  16  sign-extended ir[4:0]
off6_sext  output  16  sign-extended ir[5:0]
off9_sext  output  16  sign-extended ir[8:0]
off11_sext  output  16  sign-extended ir[10:0]
halted  output  1  HALT fetched and acknowledged
fetch_timeout  output  1  sticky; a fetch was abandoned
protocol_err  output  1  sticky; pc_ld arrived in ISSUE or WAIT

Behaviour:
- Reset: state IDLE; pc=RESET_PC; ir=0; ir_valid=0; mem_rd_en=0; halted=0; fetch_timeout=0; protocol_err=0; wait counter=0. Reset overrides everything, including mid-fetch; a late mem_rd_valid after reset is ignored because the state is IDLE.
- States: IDLE, ISSUE, WAIT, HOLD, HALT. All outputs are registered, except the decode fields, which are combinational from ir and meaningful only while ir_valid=1.
- IDLE: on fetch_req=1, go to ISSUE.
- ISSUE: mem_rd_en=1 for exactly this cycle, with mem_rd_addr=pc. Go to WAIT.
- WAIT: mem_rd_en=0 and the counter increments each cycle. On mem_rd_valid=1: ir<=mem_rd_data, pc<=pc+1 (modulo 2^ADDR_W, so FFFF wraps to 0000), ir_valid<=1, counter cleared, go to HOLD. If the counter reaches TIMEOUT without valid: fetch_timeout<=1, pc and ir unchanged, go to IDLE. Minimum fetch latency is fetch_req to ir_valid = 3 cycles with 1-cycle memory.
- HOLD: ir_valid=1 and ir is stable. On ir_ack=1: ir_valid<=0. If ir is HALT (opcode 4'b1111 and ir[7:0]==8'h25), halted<=1 and go to HALT; otherwise go to IDLE.
- HALT: terminal. fetch_req and pc_ld are ignored; only rst exits.
- pc_ld is legal in IDLE and HOLD: pc<=pc_ld_val on the next edge.
  - pc_ld with fetch_req in IDLE: the load takes effect and ISSUE uses the new pc.
  - pc_ld with ir_ack in HOLD: both take effect.
  - pc_ld in ISSUE or WAIT: ignored and protocol_err<=1.
- fetch_req outside IDLE and ir_ack outside HOLD are ignored without error.
- mem_rd_valid outside WAIT is ignored.

Test Plan:
- Reset, 1-cycle memory with mem[0]=16'h1261 (ADD R1,R1,#1): pulse fetch_req. Required: mem_rd_en high in cycle 1 with addr 0; ir_valid high in cycle 3 with ir=1261, pc=0001, opcode=1, dr=1, sr1=1, imm5_sext=0001. After ir_ack, ir_valid drops and the state returns to IDLE.
- Sign extension: mem word 16'h0FFF (BRnzp -1). Required: off9_sext=FFFF and off11_sext=FFFF; imm5_sext=FFFF for word 16'h107F.
- Wrap and branch: pc_ld_val=FFFF with fetch_req in IDLE. Required: read addr FFFF and pc=0000 after capture. Then pc_ld_val=3000 together with ir_ack in HOLD; the next fetch reads 3000.
- Timeout: TIMEOUT=4 with mem_rd_valid held low. Required: fetch_timeout=1 after 4 WAIT cycles, pc unchanged, state IDLE. A late valid is ignored, and a retry fetches correctly.
- Protocol error: pc_ld during WAIT. Required: protocol_err=1, pc still advances by 1 on capture, pc_ld_val discarded.
- HALT: mem word 16'hF025 fetched and acked. Required: halted=1 and further fetch_req produces no mem_rd_en. rst then restores pc=RESET_PC and halted=0, and reset asserted during WAIT leaves ir_valid=0.
